io_bus_v2: RTL and testbench

Parametrised IO-space register bus for the MCU. It serves the IO half of the memory map (GPIO, output-only and input-only pins, UART) behind the same start_request/request_done handshake as the memory bus. It generalises pin counts and adds three things: a buffered UART RX FIFO, per-pin GPIO edge-detect interrupts, and a combined irq line. The UART serialiser core sits outside this block and connects through the uart_* byte handshake ports.

---
 rtl/io_bus_v2.sv | 260 ++++++++++++++++++++++++++
 tb/tb_io_bus_v2.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_v2.sv
// rtl/io_bus_v2.sv - IO-space register bus with GPIO edge interrupts and UART RX FIFO
//
// Purpose: serves the IO half of the MCU memory map (output-only pins,
// input-only pins, bidirectional GPIO, UART byte interface) behind the
// start_request/request_done handshake shared with the memory bus.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   start_request, is_write       request strobe (level) and direction
//   address, write_value          register offset and write data
//   fetched_value, request_done   registered read data and completion flag
//   inputs / outputs              input-only and output-only pins
//   io_direction, io_outputs      GPIO direction (1=output) and drive values
//   io_inputs                     GPIO pin values
//   uart_tx_start/byte/done       byte handshake to the external UART TX core
//   uart_rx_valid/byte            received byte strobe from the UART RX core
//   irq                           level interrupt, any enabled GPIO edge pending
module io_bus_v2 #(
  parameter int NUM_GPIO      = 5,
  parameter int NUM_IN        = 5,
  parameter int NUM_OUT       = 4,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_request,
  input  logic                is_write,
  input  logic [7:0]          address,
  input  logic [31:0]         write_value,
  output logic [31:0]         fetched_value,
  output logic                request_done,
  input  logic [NUM_IN-1:0]   inputs,
  output logic [NUM_OUT-1:0]  outputs,
  output logic [NUM_GPIO-1:0] io_direction,
  output logic [NUM_GPIO-1:0] io_outputs,
  input  logic [NUM_GPIO-1:0] io_inputs,
  output logic                uart_tx_start,
  output logic [7:0]          uart_tx_byte,
  input  logic                uart_tx_done,
  input  logic                uart_rx_valid,
  input  logic [7:0]          uart_rx_byte,
  output logic                irq
);

  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(RX_FIFO_DEPTH);

  localparam logic [7:0] A_OUT       = 8'h00;
  localparam logic [7:0] A_IN        = 8'h01;
  localparam logic [7:0] A_DIR       = 8'h02;
  localparam logic [7:0] A_GPIO_IN   = 8'h03;
  localparam logic [7:0] A_GPIO_OUT  = 8'h04;
  localparam logic [7:0] A_IRQ_STAT  = 8'h06;
  localparam logic [7:0] A_IRQ_EN    = 8'h07;
  localparam logic [7:0] A_EDGE_SEL  = 8'h08;
  localparam logic [7:0] A_UART_CTRL = 8'h10;
  localparam logic [7:0] A_UART_STAT = 8'h11;
  localparam logic [7:0] A_TX_BUSY   = 8'h12;
  localparam logic [7:0] A_TX_DATA   = 8'h14;
  localparam logic [7:0] A_RX_DATA   = 8'h15;

  typedef enum logic [0:0] {PARSE = 1'b0, DONE = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                request_done_q, request_done_d;
  logic [31:0]         fetched_value_q, fetched_value_d;
  logic [NUM_OUT-1:0]  out_q, out_d;
  logic [NUM_IN-1:0]   in_q, in_d;
  logic [NUM_GPIO-1:0] dir_q, dir_d;
  logic [NUM_GPIO-1:0] gpio_in_q, gpio_in_d;
  logic [NUM_GPIO-1:0] gpio_prev_q, gpio_prev_d;
  logic [NUM_GPIO-1:0] gpio_out_q, gpio_out_d;
  logic [NUM_GPIO-1:0] irq_stat_q, irq_stat_d;
  logic [NUM_GPIO-1:0] irq_en_q, irq_en_d;
  logic [NUM_GPIO-1:0] edge_sel_q, edge_sel_d;
  logic                irq_q, irq_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                uart_tx_start_q, uart_tx_start_d;
  logic [7:0]          uart_tx_byte_q, uart_tx_byte_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          mem_q [RX_FIFO_DEPTH];
  logic [7:0]          mem_d [RX_FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;

  logic                access, wr_acc, rd_acc, ctrl_wr;
  logic                full, pop, flush, push_ok, drop;
  logic [NUM_GPIO-1:0] edge_hit;

  // Only the low byte of write data ever reaches a register.
  logic unused_wdata;
  assign unused_wdata = ^write_value[31:8];

  always_comb begin
    state_d         = state_q;
    fetched_value_d = fetched_value_q;
    out_d           = out_q;
    in_d            = inputs;
    dir_d           = dir_q;
    // GPIO_IN only reflects pins currently configured as inputs.
    gpio_in_d       = io_inputs & ~dir_q;
    gpio_prev_d     = gpio_in_q;
    gpio_out_d      = gpio_out_q;
    irq_stat_d      = irq_stat_q;
    irq_en_d        = irq_en_q;
    edge_sel_d      = edge_sel_q;
    tx_data_d       = tx_data_q;
    uart_tx_start_d = uart_tx_start_q;
    uart_tx_byte_d  = uart_tx_byte_q;
    ovf_d           = ovf_q;
    mem_d           = mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;

    access   = (state_q == PARSE) && start_request;
    wr_acc   = access && is_write;
    rd_acc   = access && !is_write;
    ctrl_wr  = wr_acc && (address == A_UART_CTRL);
    full     = (count_q == FULL_COUNT);
    pop      = rd_acc && (address == A_RX_DATA) && (count_q != '0);
    flush    = ctrl_wr && write_value[1];
    // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
    push_ok  = uart_rx_valid && !flush && (!full || pop);
    drop     = uart_rx_valid && !flush && full && !pop;
    edge_hit = (~edge_sel_q & gpio_in_q & ~gpio_prev_q)
             | ( edge_sel_q & ~gpio_in_q & gpio_prev_q);

    if (access) begin
      fetched_value_d = '0;
      if (!is_write) begin
        case (address)
          A_OUT:       fetched_value_d[NUM_OUT-1:0]  = out_q;
          A_IN:        fetched_value_d[NUM_IN-1:0]   = in_q;
          A_DIR:       fetched_value_d[NUM_GPIO-1:0] = dir_q;
          A_GPIO_IN:   fetched_value_d[NUM_GPIO-1:0] = gpio_in_q;
          A_GPIO_OUT:  fetched_value_d[NUM_GPIO-1:0] = gpio_out_q;
          A_IRQ_STAT:  fetched_value_d[NUM_GPIO-1:0] = irq_stat_q;
          A_IRQ_EN:    fetched_value_d[NUM_GPIO-1:0] = irq_en_q;
          A_EDGE_SEL:  fetched_value_d[NUM_GPIO-1:0] = edge_sel_q;
          A_UART_STAT: begin
            fetched_value_d[3 +: AW+1] = count_q;
            fetched_value_d[2]         = ovf_q;
            fetched_value_d[1]         = full;
            fetched_value_d[0]         = (count_q != '0);
          end
          A_TX_BUSY:   fetched_value_d[0]   = uart_tx_start_q;
          A_TX_DATA:   fetched_value_d[7:0] = tx_data_q;
          A_RX_DATA:   if (pop) fetched_value_d[7:0] = mem_q[rd_ptr_q];
          default:     ;
        endcase
      end
    end

    if (wr_acc) begin
      case (address)
        A_OUT:      out_d      = write_value[NUM_OUT-1:0];
        A_DIR:      dir_d      = write_value[NUM_GPIO-1:0];
        A_GPIO_OUT: gpio_out_d = dir_q & write_value[NUM_GPIO-1:0];
        A_IRQ_STAT: irq_stat_d = irq_stat_q & ~write_value[NUM_GPIO-1:0];
        A_IRQ_EN:   irq_en_d   = write_value[NUM_GPIO-1:0];
        A_EDGE_SEL: edge_sel_d = write_value[NUM_GPIO-1:0];
        A_TX_DATA:  tx_data_d  = write_value[7:0];
        default:    ;
      endcase
    end

    // Applied after the W1C so a fresh edge survives a same-cycle clear.
    irq_stat_d = irq_stat_d | edge_hit;
    irq_d      = |(irq_stat_q & irq_en_q);

    if (uart_tx_done) uart_tx_start_d = 1'b0;
    if (ctrl_wr && write_value[0] && !uart_tx_start_q) begin
      uart_tx_start_d = 1'b1;
      uart_tx_byte_d  = tx_data_q;
    end

    if (ctrl_wr && write_value[2]) ovf_d = 1'b0;
    if (drop) ovf_d = 1'b1;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = uart_rx_byte;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    end

    case (state_q)
      PARSE:   if (start_request) state_d = DONE;
      DONE:    if (!start_request) state_d = PARSE;
      default: state_d = PARSE;
    endcase
    request_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= PARSE;
      request_done_q  <= 1'b0;
      fetched_value_q <= '0;
      out_q           <= '0;
      in_q            <= '0;
      dir_q           <= '0;
      gpio_in_q       <= '0;
      gpio_prev_q     <= '0;
      gpio_out_q      <= '0;
      irq_stat_q      <= '0;
      irq_en_q        <= '0;
      edge_sel_q      <= '0;
      irq_q           <= 1'b0;
      tx_data_q       <= '0;
      uart_tx_start_q <= 1'b0;
      uart_tx_byte_q  <= '0;
      ovf_q           <= 1'b0;
      for (int i = 0; i < RX_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      request_done_q  <= request_done_d;
      fetched_value_q <= fetched_value_d;
      out_q           <= out_d;
      in_q            <= in_d;
      dir_q           <= dir_d;
      gpio_in_q       <= gpio_in_d;
      gpio_prev_q     <= gpio_prev_d;
      gpio_out_q      <= gpio_out_d;
      irq_stat_q      <= irq_stat_d;
      irq_en_q        <= irq_en_d;
      edge_sel_q      <= edge_sel_d;
      irq_q           <= irq_d;
      tx_data_q       <= tx_data_d;
      uart_tx_start_q <= uart_tx_start_d;
      uart_tx_byte_q  <= uart_tx_byte_d;
      ovf_q           <= ovf_d;
      mem_q           <= mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

  assign fetched_value = fetched_value_q;
  assign request_done  = request_done_q;
  assign outputs       = out_q;
  assign io_direction  = dir_q;
  assign io_outputs    = gpio_out_q;
  assign uart_tx_start = uart_tx_start_q;
  assign uart_tx_byte  = uart_tx_byte_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_io_bus_v2.sv
// tb/tb_io_bus_v2.sv - scoreboard bench for io_bus_v2
module tb_io_bus_v2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_request = 1'b0;
  logic        is_write = 1'b0;
  logic [7:0]  address = '0;
  logic [31:0] write_value = '0;
  logic [31:0] fetched_value;
  logic        request_done;
  logic [4:0]  inputs = '0;
  logic [3:0]  outputs;
  logic [4:0]  io_direction;
  logic [4:0]  io_outputs;
  logic [4:0]  io_inputs = '0;
  logic        uart_tx_start;
  logic [7:0]  uart_tx_byte;
  logic        uart_tx_done = 1'b0;
  logic        uart_rx_valid = 1'b0;
  logic [7:0]  uart_rx_byte = '0;
  logic        irq;

  always #5 clk = ~clk;

  io_bus_v2 dut (
    .clk(clk), .rst_n(rst_n), .start_request(start_request), .is_write(is_write),
    .address(address), .write_value(write_value), .fetched_value(fetched_value),
    .request_done(request_done), .inputs(inputs), .outputs(outputs),
    .io_direction(io_direction), .io_outputs(io_outputs), .io_inputs(io_inputs),
    .uart_tx_start(uart_tx_start), .uart_tx_byte(uart_tx_byte),
    .uart_tx_done(uart_tx_done), .uart_rx_valid(uart_rx_valid),
    .uart_rx_byte(uart_rx_byte), .irq(irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        check;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic done_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every rising request_done retires one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && request_done && !done_prev) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done with empty scoreboard expected none");
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.check) chk(mon_e.name, fetched_value, mon_e.val);
      end
    end
    done_prev <= request_done;
  end

  task automatic bus(input logic wr, input logic [7:0] a, input logic [31:0] d,
                     input logic ck, input logic [31:0] ev, input string nm,
                     input logic rx = 1'b0, input logic [7:0] rb = 8'h00);
    exp_t en;
    int   lat;
    en.check = ck;
    en.val   = ev;
    en.name  = nm;
    sb_q.push_back(en);
    @(negedge clk);
    start_request = 1'b1;
    is_write      = wr;
    address       = a;
    write_value   = d;
    if (rx) begin
      uart_rx_valid = 1'b1;
      uart_rx_byte  = rb;
    end
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      uart_rx_valid = 1'b0;
      lat++;
      if (request_done) break;
    end
    chk({nm, "_latency"}, 32'(lat), 32'd1);
    start_request = 1'b0;
    @(negedge clk);
    chk({nm, "_done_drop"}, {31'd0, request_done}, 32'd0);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] ev, input string nm);
    bus(1'b0, a, 32'd0, 1'b1, ev, nm);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input string nm);
    bus(1'b1, a, d, 1'b0, 32'd0, nm);
  endtask

  task automatic rx_push(input logic [7:0] b);
    @(negedge clk);
    uart_rx_valid = 1'b1;
    uart_rx_byte  = b;
    @(negedge clk);
    uart_rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] fifo_bytes [5];

  initial begin
    fifo_bytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};

    idle(3);
    chk("rst_done", {31'd0, request_done}, 32'd0);
    chk("rst_outputs", {28'd0, outputs}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_tx_start", {31'd0, uart_tx_start}, 32'd0);
    chk("rst_dir", {27'd0, io_direction}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    rd(8'h00, 32'h0, "rd_out_rst");
    rd(8'h02, 32'h0, "rd_dir_rst");
    rd(8'h11, 32'h0, "rd_ustat_rst");
    wr(8'h00, 32'hF, "wr_out");
    chk("outputs_f", {28'd0, outputs}, 32'hF);
    rd(8'h00, 32'hF, "rd_out");

    inputs = 5'h15;
    idle(2);
    rd(8'h01, 32'h15, "rd_in");

    wr(8'h02, 32'h03, "wr_dir");
    wr(8'h04, 32'h1F, "wr_gpio_out");
    chk("io_outputs_masked", {27'd0, io_outputs}, 32'h03);
    rd(8'h04, 32'h03, "rd_gpio_out");
    io_inputs = 5'b10100;
    idle(3);
    rd(8'h03, 32'h14, "rd_gpio_in");

    io_inputs = 5'b00000;
    idle(3);
    wr(8'h06, 32'h1F, "clr_stat");
    rd(8'h06, 32'h0, "rd_stat_clr");
    wr(8'h07, 32'h04, "wr_irq_en");
    wr(8'h08, 32'h00, "wr_edge_rise");
    io_inputs = 5'b00100;
    idle(4);
    rd(8'h06, 32'h04, "rd_stat_rise");
    chk("irq_set", {31'd0, irq}, 32'd1);
    wr(8'h06, 32'h04, "w1c_stat");
    rd(8'h06, 32'h0, "rd_stat_w1c");
    chk("irq_clr", {31'd0, irq}, 32'd0);
    io_inputs = 5'b00000;
    idle(4);
    rd(8'h06, 32'h0, "rd_stat_fall_ignored");
    chk("irq_fall_ignored", {31'd0, irq}, 32'd0);

    wr(8'h08, 32'h04, "wr_edge_fall");
    io_inputs = 5'b00100;
    idle(4);
    rd(8'h06, 32'h0, "rd_stat_rise_ignored");
    io_inputs = 5'b00000;
    idle(4);
    rd(8'h06, 32'h04, "rd_stat_fall");
    wr(8'h06, 32'h04, "w1c_stat2");

    for (int i = 0; i < 5; i++) rx_push(fifo_bytes[i]);
    rd(8'h11, 32'h27, "ustat_full_ovf");
    for (int i = 0; i < 4; i++) rd(8'h15, {24'd0, fifo_bytes[i]}, "rx_pop");
    rd(8'h15, 32'h0, "rx_pop_empty");
    rd(8'h11, 32'h04, "ustat_empty_ovf");
    wr(8'h10, 32'h4, "clr_ovf");
    rd(8'h11, 32'h0, "ustat_ovf_clr");

    rx_push(8'hB1);
    rx_push(8'hB2);
    rx_push(8'hB3);
    rx_push(8'hB4);
    rd(8'h11, 32'h23, "ustat_full");
    bus(1'b0, 8'h15, 32'd0, 1'b1, 32'hB1, "pop_push_full", 1'b1, 8'hB5);
    rd(8'h11, 32'h23, "ustat_full_after_pp");
    rd(8'h15, 32'hB2, "rx_b2");
    rd(8'h15, 32'hB3, "rx_b3");
    rd(8'h15, 32'hB4, "rx_b4");
    rd(8'h15, 32'hB5, "rx_b5");
    rd(8'h11, 32'h0, "ustat_drained");

    rx_push(8'hC1);
    rx_push(8'hC2);
    rd(8'h11, 32'h11, "ustat_two");
    wr(8'h10, 32'h2, "flush");
    rd(8'h11, 32'h0, "ustat_flushed");
    bus(1'b1, 8'h10, 32'h2, 1'b0, 32'd0, "flush_push", 1'b1, 8'hC3);
    rd(8'h11, 32'h0, "ustat_flush_wins");
    rd(8'h15, 32'h0, "rx_after_flush");

    wr(8'h14, 32'h55, "wr_tx_data");
    wr(8'h10, 32'h1, "tx_go");
    chk("tx_start", {31'd0, uart_tx_start}, 32'd1);
    chk("tx_byte", {24'd0, uart_tx_byte}, 32'h55);
    rd(8'h12, 32'h1, "rd_tx_busy");
    wr(8'h14, 32'h66, "wr_tx_data_busy");
    wr(8'h10, 32'h1, "tx_go_busy");
    chk("tx_byte_held", {24'd0, uart_tx_byte}, 32'h55);
    rd(8'h14, 32'h66, "rd_tx_data");
    rd(8'h10, 32'h0, "rd_ctrl_zero");
    @(negedge clk);
    uart_tx_done = 1'b1;
    @(negedge clk);
    uart_tx_done = 1'b0;
    chk("tx_start_clr", {31'd0, uart_tx_start}, 32'd0);
    rd(8'h12, 32'h0, "rd_tx_idle");
    wr(8'h10, 32'h1, "tx_go2");
    chk("tx_byte2", {24'd0, uart_tx_byte}, 32'h66);

    wr(8'h30, 32'hFF, "wr_unmapped");
    rd(8'h30, 32'h0, "rd_unmapped");

    @(negedge clk);
    rst_n         = 1'b0;
    start_request = 1'b1;
    is_write      = 1'b1;
    address       = 8'h00;
    write_value   = 32'h3;
    idle(2);
    chk("abort_done", {31'd0, request_done}, 32'd0);
    chk("abort_outputs", {28'd0, outputs}, 32'd0);
    chk("abort_tx_start", {31'd0, uart_tx_start}, 32'd0);
    start_request = 1'b0;
    rst_n = 1'b1;
    idle(2);
    chk("abort_done_after", {31'd0, request_done}, 32'd0);

    idle(2);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
